// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: prefetching read adapter turning a 1-cycle-latency FIFO read port into a valid/ready stream
module fifo_stream_reader #(
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DWIDTH-1:0] fifo_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic [1:0]        level
);
  logic [DWIDTH-1:0] mem [3];
  logic [1:0] occ, head, tail;
  logic inflight, capture, transfer;
  function automatic logic [1:0] wrap_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction
  // Issue depends only on registered state, so m_ready never reaches fifo_rd_en combinationally.
  always_comb begin
    fifo_rd_en = !rst && !flush && !fifo_empty && (({1'b0, occ} + {2'b0, inflight}) <= 3'd2);
    m_valid    = occ != 2'd0;
    m_data     = mem[head];
    capture    = inflight && !flush;
    transfer   = m_valid && m_ready;
    level      = occ;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= '0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      for (int i = 0; i < 3; i++) mem[i] <= '0;
    end else if (flush) begin
      occ      <= '0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= fifo_rd_en;
      occ      <= occ + 2'(capture) - 2'(transfer);
      if (capture) begin
        mem[tail] <= fifo_rd_data;
        tail      <= wrap_inc(tail);
      end
      if (transfer) head <= wrap_inc(head);
    end
  end
endmodule
